// File: rtl/glitch_pulse_gen_if.sv
// Raw button, timing-control and status signals between the glitch generator
// (slave) and whatever drives it (master).
interface glitch_pulse_gen_if #(
    parameter int DELAY_W = 24,
    parameter int WIDTH_W = 16
);
    logic               trig_raw;
    logic               arm_raw;
    logic [DELAY_W-1:0] delay_cycles;
    logic [WIDTH_W-1:0] width_cycles;
    logic               enter_out;
    logic               glitch_out;
    logic               armed;
    logic               done;

    modport master (
        output trig_raw, arm_raw, delay_cycles, width_cycles,
        input  enter_out, glitch_out, armed, done
    );

    modport slave (
        input  trig_raw, arm_raw, delay_cycles, width_cycles,
        output enter_out, glitch_out, armed, done
    );
endinterface

// File: rtl/glitch_pulse_gen.sv
// Button conditioning plus a timed glitch-pulse generator for the password checker.
// Optional macro GLITCH_TRAIN_EN: emit a train of four pulses separated by equal gaps.
module glitch_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 480_000,
    parameter int DELAY_W         = 24,
    parameter int WIDTH_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    glitch_pulse_gen_if.slave bus
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_DONE  = 3'd4
`ifdef GLITCH_TRAIN_EN
        , S_GAP = 3'd5
`endif
    } state_t;

    // Index 0 is the Enter button, index 1 the Arm button.
    logic [1:0]             w_raw;
    logic [SYNC_STAGES-1:0] r_sync   [2];
    logic [DB_W-1:0]        r_db_cnt [2];
    logic [1:0]             r_lvl;
    logic [1:0]             r_lvl_q;
    logic [1:0]             w_rise;
    logic                   w_trig_rise;
    logic                   w_arm_rise;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DELAY_W-1:0] r_dly, w_dly_nxt;
    logic [WIDTH_W-1:0] r_wid, w_wid_nxt;
    logic               r_glitch, w_glitch_nxt;
    logic [CNT_W-1:0]   w_dly_ext;
    logic [CNT_W-1:0]   w_wid_m1;
`ifdef GLITCH_TRAIN_EN
    logic [1:0]         r_pulses, w_pulses_nxt;
`endif

    assign w_raw       = {bus.arm_raw, bus.trig_raw};
    assign w_rise      = r_lvl & ~r_lvl_q;
    assign w_trig_rise = w_rise[0];
    assign w_arm_rise  = w_rise[1];
    assign w_dly_ext   = CNT_W'(r_dly);
    assign w_wid_m1    = CNT_W'(r_wid) - CNT_W'(1);

    // Synchronize both raw buttons, debounce them and keep a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i]   <= '0;
                r_db_cnt[i] <= '0;
            end
            r_lvl   <= 2'b00;
            r_lvl_q <= 2'b00;
        end else begin
            r_lvl_q <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[i][SYNC_STAGES-1] == r_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_lvl[i]    <= r_sync[i][SYNC_STAGES-1];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // State, counter, captured timing and the glitch flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dly    <= '0;
            r_wid    <= '0;
            r_glitch <= 1'b0;
`ifdef GLITCH_TRAIN_EN
            r_pulses <= 2'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dly    <= w_dly_nxt;
            r_wid    <= w_wid_nxt;
            r_glitch <= w_glitch_nxt;
`ifdef GLITCH_TRAIN_EN
            r_pulses <= w_pulses_nxt;
`endif
        end
    end

    // Next-state logic; an arm edge while a shot is in flight aborts it.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dly_nxt    = r_dly;
        w_wid_nxt    = r_wid;
        w_glitch_nxt = r_glitch;
`ifdef GLITCH_TRAIN_EN
        w_pulses_nxt = r_pulses;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_arm_rise) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_arm_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_trig_rise) begin
                    w_state_nxt = S_DELAY;
                    w_dly_nxt   = bus.delay_cycles;
                    w_wid_nxt   = bus.width_cycles;
                    w_cnt_nxt   = '0;
`ifdef GLITCH_TRAIN_EN
                    w_pulses_nxt = 2'd0;
`endif
                end else begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_DELAY: begin
                if (w_arm_rise) begin
                    w_state_nxt  = S_IDLE;
                    w_glitch_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == w_dly_ext) begin
                    if (r_wid == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt  = S_PULSE;
                        w_glitch_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (w_arm_rise) begin
                    w_state_nxt  = S_IDLE;
                    w_glitch_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == w_wid_m1) begin
                    w_glitch_nxt = 1'b0;
                    w_cnt_nxt    = '0;
`ifdef GLITCH_TRAIN_EN
                    if (r_pulses == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt  = S_GAP;
                        w_pulses_nxt = r_pulses + 2'd1;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef GLITCH_TRAIN_EN
            S_GAP: begin
                if (w_arm_rise) begin
                    w_state_nxt  = S_IDLE;
                    w_glitch_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == w_wid_m1) begin
                    w_state_nxt  = S_PULSE;
                    w_glitch_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                if (!r_lvl[0]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_glitch_nxt = 1'b0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    assign bus.enter_out  = r_lvl[0];
    assign bus.glitch_out = r_glitch;
    assign bus.armed      = (r_state == S_ARMED);
    assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench for glitch_pulse_gen: stimulus queues expected output edges
// with their cycle numbers, a negedge monitor matches every observed edge.
module tb_glitch_pulse_gen;
    localparam int DW = 24;
    localparam int WW = 16;
`ifdef GLITCH_TRAIN_EN
    localparam int NP = 4;
`else
    localparam int NP = 1;
`endif

    localparam int K_EN_R  = 0;
    localparam int K_EN_F  = 1;
    localparam int K_ARM_R = 2;
    localparam int K_ARM_F = 3;
    localparam int K_GL_R  = 4;
    localparam int K_GL_F  = 5;
    localparam int K_DN_R  = 6;
    localparam int K_DN_F  = 7;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    logic p_en  = 1'b0;
    logic p_arm = 1'b0;
    logic p_gl  = 1'b0;
    logic p_dn  = 1'b0;

    glitch_pulse_gen_if #(.DELAY_W(DW), .WIDTH_W(WW)) bus ();

    glitch_pulse_gen #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .DELAY_W(DW),
        .WIDTH_W(WW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_EN_R:  return "enter_rise";
            K_EN_F:  return "enter_fall";
            K_ARM_R: return "armed_rise";
            K_ARM_F: return "armed_fall";
            K_GL_R:  return "glitch_rise";
            K_GL_F:  return "glitch_fall";
            K_DN_R:  return "done_rise";
            K_DN_F:  return "done_fall";
            default: return "unknown";
        endcase
    endfunction

    function automatic void push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: flag overdue expectations, then match each observed output edge.
    always @(negedge clk) begin
        logic [7:0] seen;
        string      nxt;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing %s: expected at cycle %0d, not seen by cycle %0d",
                     kname(exp_q[0].kind), exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        seen = 8'd0;
        seen[K_EN_R]  = bus.enter_out  & ~p_en;
        seen[K_EN_F]  = ~bus.enter_out &  p_en;
        seen[K_ARM_R] = bus.armed      & ~p_arm;
        seen[K_ARM_F] = ~bus.armed     &  p_arm;
        seen[K_GL_R]  = bus.glitch_out & ~p_gl;
        seen[K_GL_F]  = ~bus.glitch_out & p_gl;
        seen[K_DN_R]  = bus.done       & ~p_dn;
        seen[K_DN_F]  = ~bus.done      &  p_dn;
        for (int k = 0; k < 8; k++) begin
            if (seen[k]) begin
                total++;
                if (exp_q.size() > 0 && exp_q[0].kind == k && exp_q[0].cyc == cyc) begin
                    void'(exp_q.pop_front());
                end else begin
                    bad++;
                    if (exp_q.size() > 0) nxt = $sformatf("%s at cycle %0d", kname(exp_q[0].kind), exp_q[0].cyc);
                    else nxt = "no edge";
                    $display("FAIL event %s: seen at cycle %0d, expected %s", kname(k), cyc, nxt);
                end
            end
        end
        p_en  <= bus.enter_out;
        p_arm <= bus.armed;
        p_gl  <= bus.glitch_out;
        p_dn  <= bus.done;
    end

    // Arm from IDLE: debounced arm edge 6 cycles later, ARMED the cycle after.
    task automatic arm_press(input int kind);
        int a;
        a = cyc;
        bus.arm_raw = 1'b1;
        push(kind, a + 7);
        wait_cyc(10);
        bus.arm_raw = 1'b0;
        wait_cyc(10);
    endtask

    task automatic trig_release(input logic in_done);
        int r;
        r = cyc;
        bus.trig_raw = 1'b0;
        push(K_EN_F, r + 6);
        if (in_done) push(K_DN_F, r + 7);
        wait_cyc(12);
    endtask

    // One armed shot: E = c+6, glitch pulses start at E+2+D.
    task automatic shot(input int d, input int w);
        int c;
        arm_press(K_ARM_R);
        c = cyc;
        bus.delay_cycles = DW'(d);
        bus.width_cycles = WW'(w);
        bus.trig_raw     = 1'b1;
        push(K_EN_R, c + 6);
        push(K_ARM_F, c + 7);
        if (w > 0) begin
            for (int p = 0; p < NP; p++) begin
                push(K_GL_R, c + 8 + d + 2 * p * w);
                push(K_GL_F, c + 8 + d + w + 2 * p * w);
            end
            push(K_DN_R, c + 8 + d + (2 * NP - 1) * w);
        end else begin
            push(K_DN_R, c + 8 + d);
        end
        wait_cyc(8);
        bus.delay_cycles = DW'(d + 37);
        bus.width_cycles = WW'(w + 5);
        wait_cyc(d + 8 * w + 15);
        check("done_held", bus.done, 1);
        trig_release(1'b1);
        check("idle_armed", bus.armed, 0);
        check("idle_done", bus.done, 0);
    endtask

    initial begin
        int c;
        bus.trig_raw     = 1'b0;
        bus.arm_raw      = 1'b0;
        bus.delay_cycles = '0;
        bus.width_cycles = '0;
        wait_cyc(3);
        check("rst_enter", bus.enter_out, 0);
        check("rst_glitch", bus.glitch_out, 0);
        check("rst_armed", bus.armed, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Debounce: 2-cycle bounces are rejected, a stable level lands 6 cycles later.
        for (int i = 0; i < 10; i++) begin
            bus.trig_raw = ~bus.trig_raw;
            wait_cyc(2);
        end
        c = cyc;
        bus.trig_raw = 1'b1;
        push(K_EN_R, c + 6);
        wait_cyc(10);
        check("dbnc_idle", bus.armed, 0);
        trig_release(1'b0);

        shot(10, 3);
        shot(0, 1);
        shot(7, 0);

        // Abort: arm edge while counting a long delay.
        arm_press(K_ARM_R);
        c = cyc;
        bus.delay_cycles = DW'(100);
        bus.width_cycles = WW'(5);
        bus.trig_raw     = 1'b1;
        push(K_EN_R, c + 6);
        push(K_ARM_F, c + 7);
        wait_cyc(20);
        bus.arm_raw = 1'b1;
        wait_cyc(10);
        check("abort_armed", bus.armed, 0);
        check("abort_glitch", bus.glitch_out, 0);
        bus.arm_raw = 1'b0;
        wait_cyc(100);
        check("abort_late_glitch", bus.glitch_out, 0);
        check("abort_done", bus.done, 0);
        trig_release(1'b0);

        // Asynchronous reset in the middle of a long pulse.
        arm_press(K_ARM_R);
        c = cyc;
        bus.delay_cycles = DW'(2);
        bus.width_cycles = WW'(50);
        bus.trig_raw     = 1'b1;
        push(K_EN_R, c + 6);
        push(K_ARM_F, c + 7);
        push(K_GL_R, c + 10);
        wait_cyc(20);
        c = cyc;
        push(K_EN_F, c + 1);
        push(K_GL_F, c + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_glitch", bus.glitch_out, 0);
        check("arst_enter", bus.enter_out, 0);
        check("arst_armed", bus.armed, 0);
        check("arst_done", bus.done, 0);
        wait_cyc(3);
        bus.trig_raw = 1'b0;
        rst_n = 1'b1;
        wait_cyc(10);
        check("post_rst_armed", bus.armed, 0);
        check("post_rst_done", bus.done, 0);
        arm_press(K_ARM_R);
        arm_press(K_ARM_F);

`ifdef GLITCH_TRAIN_EN
        shot(5, 2);
`endif

        wait_cyc(20);
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing %s: expected at cycle %0d, never seen",
                     kname(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
